// File: rtl/my_i2s_rx_if.sv
// AXI-Stream bundle carrying packed stereo frames out of the I2S receiver.
interface my_i2s_rx_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                      tvalid;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;
    logic                      tready;

    modport master (
        output tvalid,
        output tdata,
        output tstrb,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tstrb,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/my_i2s_rx.sv
// I2S slave receiver: oversamples bclk/lrclk/sdata in the AXIS clock domain and
// emits each complete {left,right} frame as one beat through a show-ahead FIFO.
module my_i2s_rx #(
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLE_BITS            = 16,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic        m00_axis_aclk,
    input  logic        m00_axis_aresetn,
    input  logic        bclk,
    input  logic        lrclk,
    input  logic        sdata,
    my_i2s_rx_if.master m00_axis,
    output logic        overflow
);
    localparam int DW    = C_M00_AXIS_TDATA_WIDTH;
    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [2:0]             bclk_pipe_r;
    logic [1:0]             lr_pipe_r;
    logic [1:0]             sd_pipe_r;
    logic                   bclk_rise_s;
    logic                   lr_s;
    logic                   sd_s;

    logic                   prev_lr_r;
    logic [CNT_W-1:0]       bitcnt_r;
    logic                   aligned_r;
    logic                   left_ok_r;
    logic                   push_r;
    logic [SAMPLE_BITS-1:0] left_sr_r;
    logic [SAMPLE_BITS-1:0] right_sr_r;

    logic [DW-1:0]          mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [LVL_W-1:0]       level_r;
    logic                   tvalid_r;
    logic [DW-1:0]          tdata_r;
    logic                   overflow_r;

    logic                   do_pop_s;
    logic                   do_push_s;
    logic                   drop_s;
    logic                   full_s;
    logic [LVL_W-1:0]       remain_s;
    logic [LVL_W-1:0]       level_next_s;
    logic [PTR_W-1:0]       rd_next_s;
    logic [DW-1:0]          push_data_s;
    logic [DW-1:0]          head_next_s;

    // Two-flop synchronisers; bclk keeps a third stage for edge detection.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            bclk_pipe_r <= 3'b000;
            lr_pipe_r   <= 2'b00;
            sd_pipe_r   <= 2'b00;
        end else begin
            bclk_pipe_r <= {bclk_pipe_r[1:0], bclk};
            lr_pipe_r   <= {lr_pipe_r[0], lrclk};
            sd_pipe_r   <= {sd_pipe_r[0], sdata};
        end
    end

    assign bclk_rise_s = bclk_pipe_r[1] & ~bclk_pipe_r[2];
    assign lr_s        = lr_pipe_r[1];
    assign sd_s        = sd_pipe_r[1];
    assign push_data_s = {left_sr_r, right_sr_r};

    // Slot tracking and deserialisation; a right word is pushed only behind a full left word.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            prev_lr_r  <= 1'b0;
            bitcnt_r   <= {CNT_W{1'b0}};
            aligned_r  <= 1'b0;
            left_ok_r  <= 1'b0;
            push_r     <= 1'b0;
            left_sr_r  <= {SAMPLE_BITS{1'b0}};
            right_sr_r <= {SAMPLE_BITS{1'b0}};
        end else begin
            push_r <= 1'b0;
            if (push_r) begin
                left_ok_r <= 1'b0;
            end
            if (bclk_rise_s) begin
                prev_lr_r <= lr_s;
                if (lr_s != prev_lr_r) begin
                    // The bit at a word-select change still belongs to the old word.
                    bitcnt_r  <= {CNT_W{1'b0}};
                    aligned_r <= 1'b1;
                    left_ok_r <= ~prev_lr_r & (bitcnt_r == FULL_CNT);
                end else if (aligned_r && (bitcnt_r < FULL_CNT)) begin
                    if (lr_s) begin
                        right_sr_r <= {right_sr_r[SAMPLE_BITS-2:0], sd_s};
                    end else begin
                        left_sr_r  <= {left_sr_r[SAMPLE_BITS-2:0], sd_s};
                    end
                    bitcnt_r <= bitcnt_r + CNT_ONE;
                    push_r   <= lr_s & (bitcnt_r == LAST_CNT) & left_ok_r;
                end
            end
        end
    end

    // FIFO next-state; the registered head is refreshed from whatever will sit at rd_ptr.
    always_comb begin
        do_pop_s     = tvalid_r & m00_axis.tready;
        full_s       = (level_r == LVL_FULL);
        do_push_s    = push_r & (~full_s | do_pop_s);
        drop_s       = push_r & full_s & ~do_pop_s;
        remain_s     = level_r - LVL_W'(do_pop_s);
        level_next_s = remain_s + LVL_W'(do_push_s);
        rd_next_s    = rd_ptr_r + PTR_W'(do_pop_s);
        if (level_next_s == {LVL_W{1'b0}}) begin
            head_next_s = tdata_r;
        end else if (remain_s == {LVL_W{1'b0}}) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage, pointers and registered stream outputs.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            tvalid_r   <= 1'b0;
            tdata_r    <= {DW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r   <= rd_next_s;
            level_r    <= level_next_s;
            tvalid_r   <= (level_next_s != {LVL_W{1'b0}});
            tdata_r    <= head_next_s;
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign m00_axis.tvalid = tvalid_r;
    assign m00_axis.tdata  = tdata_r;
    assign m00_axis.tstrb  = {(DW/8){1'b1}};
    assign m00_axis.tlast  = 1'b1;
    assign overflow        = overflow_r;
endmodule

// File: tb/tb_my_i2s_rx.sv
// Directed bench for my_i2s_rx: drives I2S frames and checks packed beats,
// latency, backpressure, overflow and reset behaviour against hand-computed values.
module tb_my_i2s_rx;
    logic clk;
    logic rst_n;
    logic bclk;
    logic lrclk;
    logic sdata;
    logic overflow;

    my_i2s_rx_if #(.DATA_WIDTH(32)) axis_if ();

    my_i2s_rx #(
        .C_M00_AXIS_TDATA_WIDTH(32),
        .SAMPLE_BITS(16),
        .FIFO_DEPTH(4)
    ) dut (
        .m00_axis_aclk(clk),
        .m00_axis_aresetn(rst_n),
        .bclk(bclk),
        .lrclk(lrclk),
        .sdata(sdata),
        .m00_axis(axis_if),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_mis;
    int          cyc;
    int          last_rise_cyc;
    int          rise_cyc;
    int          hi_cnt;
    logic        tvalid_q;
    logic        last_tlast;
    logic [3:0]  last_tstrb;
    logic [31:0] beats [$];

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Handshake monitor: tready only changes just after a rising edge.
    initial begin
        rise_cyc = 0;
        hi_cnt   = 0;
        tvalid_q = 1'b0;
    end
    always @(negedge clk) begin
        if (axis_if.tvalid && axis_if.tready) begin
            beats.push_back(axis_if.tdata);
            last_tlast <= axis_if.tlast;
            last_tstrb <= axis_if.tstrb;
        end
        if (axis_if.tvalid && !tvalid_q) rise_cyc <= cyc;
        if (axis_if.tvalid) hi_cnt <= hi_cnt + 1;
        tvalid_q <= axis_if.tvalid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] obs;
        obs = 32'hxxxxxxxx;
        if (idx < beats.size()) obs = beats[idx];
        chk(tag, obs, exp);
    endtask

    task automatic send_bit(input logic lr, input logic sd, input logic pulse);
        @(negedge clk);
        bclk = 1'b0; lrclk = lr; sdata = sd;
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        last_rise_cyc = cyc;
        if (pulse) begin
            // One-cycle accept aligned with the push this rise produces.
            repeat (3) @(posedge clk);
            #1 axis_if.tready = 1'b1;
            @(posedge clk);
            #1 axis_if.tready = 1'b0;
        end else begin
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] data, input int nbits, input logic pulse_last);
        send_bit(lr, 1'b1, 1'b0);
        for (int b = nbits - 1; b >= 0; b--) send_bit(lr, data[b], pulse_last && (b == 0));
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits);
        send_slot(1'b0, l, nbits, 1'b0);
        send_slot(1'b1, r, nbits, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 axis_if.tready = v;
    endtask

    task automatic settle();
        repeat (16) @(negedge clk);
    endtask

    initial begin
        int          base;
        int          hbase;
        logic [15:0] iv;
        logic [11:0] stub;

        n_cmp = 0; n_mis = 0; last_rise_cyc = 0;
        rst_n = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
        axis_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", {31'd0, axis_if.tvalid}, 32'd0);
        chk("rst_tdata", axis_if.tdata, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;

        // Basic frame, beat format and latency.
        base = beats.size(); hbase = hi_cnt;
        send_bit(1'b1, 1'b0, 1'b0);
        send_frame(32'h0000AA55, 32'h00008001, 16);
        settle();
        chk("t1_count", 32'(beats.size() - base), 32'd1);
        chk_beat("t1_data", base, 32'hAA558001);
        chk("t1_tlast", {31'd0, last_tlast}, 32'd1);
        chk("t1_tstrb", {28'd0, last_tstrb}, 32'h0000000F);
        chk("t1_latency", 32'(rise_cyc - last_rise_cyc), 32'd4);
        chk("t1_pulse", 32'(hi_cnt - hbase), 32'd1);

        // 32-bit slots keep the first 16 bits of each channel.
        base = beats.size();
        send_frame(32'h1234ABCD, 32'h5678EF01, 32);
        settle();
        chk("t4_count", 32'(beats.size() - base), 32'd1);
        chk_beat("t4_data", base, 32'h12345678);

        // Short left slot suppresses its frame only.
        base = beats.size();
        send_slot(1'b0, 32'h000000A5, 8, 1'b0);
        send_slot(1'b1, 32'h00001357, 16, 1'b0);
        send_frame(32'h00002468, 32'h0000ACE0, 16);
        settle();
        chk("t5_count", 32'(beats.size() - base), 32'd1);
        chk_beat("t5_data", base, 32'h2468ACE0);

        // Backpressure: four held, two dropped, sticky overflow.
        set_ready(1'b0);
        base = beats.size();
        for (int i = 0; i < 6; i++) begin
            iv = 16'(i);
            send_frame({16'h0000, iv}, {16'h0000, ~iv}, 16);
        end
        settle();
        chk("t2_overflow", {31'd0, overflow}, 32'd1);
        chk("t2_tvalid", {31'd0, axis_if.tvalid}, 32'd1);
        chk("t2_head", axis_if.tdata, 32'h0000FFFF);
        set_ready(1'b1);
        settle();
        chk("t2_count", 32'(beats.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            iv = 16'(i);
            chk_beat($sformatf("t2_beat%0d", i), base + i, {iv, ~iv});
        end

        // Full FIFO with simultaneous push and pop keeps every word.
        do_reset();
        set_ready(1'b0);
        base = beats.size();
        send_bit(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_frame(32'h00007000 + 32'(i), 32'h00007100 + 32'(i), 16);
        send_slot(1'b0, 32'h00007004, 16, 1'b0);
        send_slot(1'b1, 32'h00007104, 16, 1'b1);
        settle();
        chk("t7_overflow", {31'd0, overflow}, 32'd0);
        chk("t7_head", axis_if.tdata, 32'h70017101);
        set_ready(1'b1);
        settle();
        chk("t7_count", 32'(beats.size() - base), 32'd5);
        for (int i = 0; i < 5; i++)
            chk_beat($sformatf("t7_beat%0d", i), base + i, {16'h7000 + 16'(i), 16'h7100 + 16'(i)});

        // Start in the middle of a right slot.
        do_reset();
        base = beats.size();
        stub = 12'hABC;
        for (int b = 11; b >= 0; b--) send_bit(1'b1, stub[b], 1'b0);
        send_frame(32'h00003C3C, 32'h0000C3C3, 16);
        settle();
        chk("t3_count", 32'(beats.size() - base), 32'd1);
        chk_beat("t3_data", base, 32'h3C3CC3C3);

        // Reset mid-left word with data pending and overflow set.
        set_ready(1'b0);
        for (int i = 0; i < 5; i++) send_frame(32'h00001100 + 32'(i), 32'h00002200 + 32'(i), 16);
        send_bit(1'b0, 1'b1, 1'b0);
        for (int b = 15; b >= 8; b--) send_bit(1'b0, b[0], 1'b0);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", {31'd0, axis_if.tvalid}, 32'd0);
        chk("t6_rst_tdata", axis_if.tdata, 32'd0);
        chk("t6_rst_overflow", {31'd0, overflow}, 32'd0);
        repeat (3) @(negedge clk); rst_n = 1'b1;
        set_ready(1'b1);
        base = beats.size();
        for (int b = 7; b >= 0; b--) send_bit(1'b0, b[0], 1'b0);
        send_slot(1'b1, 32'h00004444, 16, 1'b0);
        send_frame(32'h00006A6A, 32'h00005959, 16);
        settle();
        chk("t6_count", 32'(beats.size() - base), 32'd1);
        chk_beat("t6_data", base, 32'h6A6A5959);
        chk("t6_overflow", {31'd0, overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
